regfile16x16_wb: RTL and testbench
==================================

REGFILE16X16_WB -- requirements
Module: regfile16x16_wb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, giving the address width; the array depth is 2**ADDR_W entries (16).
REQ-003 The block SHALL have parameter R0_ZERO, default 1; when 1, register 0 reads as zero and writes to it are discarded.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port wr_valid, input, 1 bit: write request.
REQ-007 The block SHALL have port wr_ready, output, 1 bit: write can be accepted.
REQ-008 The block SHALL have port wr_addr, input, ADDR_W bits: write address.
REQ-009 The block SHALL have port wr_data, input, DATA_W bits: write data.
REQ-010 The block SHALL have ports rd_addr_a and rd_addr_b, input, ADDR_W bits each: read addresses.
REQ-011 The block SHALL have ports rd_data_a and rd_data_b, output, DATA_W bits each: read data; these feed the downstream 16:1 read mux.
REQ-012 The block SHALL have port clr_req, input, 1 bit: request a clear sweep of the whole array.
REQ-013 The block SHALL have port busy, output, 1 bit: high while the clear sweep runs.
REQ-014 The block SHALL have port clr_done, output, 1 bit: one-cycle pulse at the end of the sweep.

Function
REQ-015 The block SHALL run an FSM with two states, IDLE and CLEAR.
REQ-016 wr_ready SHALL be 1 in IDLE and 0 in CLEAR, decoded combinationally from the state.
REQ-017 A write SHALL be accepted on a rising edge where wr_valid and wr_ready are both 1.
REQ-018 At acceptance the block SHALL capture wr_addr and wr_data into a one-entry pending buffer and set pend_vld.
REQ-019 On the next edge the block SHALL commit the pending buffer into the array and clear pend_vld, unless a new write is accepted on that edge, in which case it commits and reloads in the same edge.
REQ-020 Back-to-back writes, one per cycle, SHALL be sustained with no stall in IDLE.
REQ-021 Reads SHALL be combinational; address 0 with R0_ZERO=1 returns 0.
REQ-022 Otherwise, if pend_vld is set and pend_addr equals the read address, a read SHALL return pend_data (bypass).
REQ-023 Otherwise a read SHALL return the array entry.
REQ-024 Net write-to-read latency: data accepted at edge N SHALL be readable immediately after edge N.
REQ-025 Ports A and B SHALL be independent; the same address on both SHALL return identical data.
REQ-026 A write to address 0 with R0_ZERO=1 SHALL be accepted (handshake completes) but SHALL NOT change state or bypass.
REQ-027 clr_req sampled high in IDLE SHALL move the FSM to CLEAR with the sweep counter at 0; clr_req in CLEAR SHALL be ignored.
REQ-028 In CLEAR the block SHALL zero the entry at the counter index each cycle, for indices 0 to 15, which takes 16 cycles.
REQ-029 After zeroing index 15 the block SHALL return to IDLE and pulse clr_done for exactly that one cycle.
REQ-030 busy SHALL be 1 exactly while the state is CLEAR.
REQ-031 A pending commit SHALL still occur during CLEAR.
REQ-032 If a pending commit and a sweep write target the same index in the same cycle, the sweep write SHALL win.
REQ-033 When wr_valid and clr_req are high on the same IDLE edge, the write SHALL be accepted and its data SHALL be zero after the sweep.
REQ-034 On sweep completion every entry SHALL read 0, regardless of writes accepted before or with clr_req.

Reset
REQ-035 rst_n low SHALL asynchronously zero all array entries, clear pend_vld, pend_addr and pend_data, set the state to IDLE and the counter to 0.
REQ-036 During and after reset, outputs SHALL be: busy=0, clr_done=0, wr_ready=1, rd_data_a=rd_data_b=0.
REQ-037 Reset asserted mid-sweep or with a write pending SHALL abort it; no partial commit occurs after reset release.

Verification
REQ-038 Write 0xBEEF to addr 5 at edge N, with rd_addr_a=5 -> rd_data_a=0xBEEF after edge N (bypass) and after edge N+1 (array).
REQ-039 Writes to addrs 1, 2, 3 on consecutive cycles with 0x1111, 0x2222, 0x3333, wr_ready held 1 -> all three read back correctly on ports A and B.
REQ-040 Write 0xFFFF to addr 0 with R0_ZERO=1 -> handshake completes; rd_data_a at addr 0 = 0.
REQ-041 Fill all 16 entries, then assert clr_req -> busy=1 for 16 cycles, wr_ready=0, clr_done one pulse, all entries read 0; wr_valid during busy is not accepted.
REQ-042 wr_valid (addr 0, 0x1234) on the same edge as clr_req -> entry 0 = 0 after the sweep.
REQ-043 rst_n low in sweep cycle 7 -> busy=0 immediately; after release the state is IDLE, all entries are 0 and wr_ready=1.

Source files
------------

// File: rtl/regfile16x16_wb.sv
// 16x16 register file with a one-entry write-commit buffer, bypassed combinational
// reads, and a one-entry-per-cycle clear sweep controlled by a two-state FSM.
module regfile16x16_wb #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              pend_vld;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic              accept;
  logic              wr_zero;
  logic              last_idx;
  logic              clr_done_q;

  assign accept   = wr_valid && wr_ready;
  assign wr_zero  = R0_ZERO && (wr_addr == '0);
  assign last_idx = (cnt == '1);
  assign clr_done = clr_done_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        busy    = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (last_idx) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pend_vld   <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      clr_done_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      clr_done_q <= (state == CLEAR) && last_idx;
      // Discarded r0 writes complete the handshake but never load the buffer.
      if (accept && !wr_zero) begin
        pend_vld  <= 1'b1;
        pend_addr <= wr_addr;
        pend_data <= wr_data;
      end else begin
        pend_vld  <= 1'b0;
      end
      if (pend_vld) mem[pend_addr] <= pend_data;
      // Later assignment lets the sweep override a same-index commit.
      if (state == CLEAR) mem[cnt] <= '0;
    end
  end

  always_comb begin
    rd_data_a = mem[rd_addr_a];
    if (pend_vld && (pend_addr == rd_addr_a)) rd_data_a = pend_data;
    if (R0_ZERO && (rd_addr_a == '0)) rd_data_a = '0;
  end

  always_comb begin
    rd_data_b = mem[rd_addr_b];
    if (pend_vld && (pend_addr == rd_addr_b)) rd_data_b = pend_data;
    if (R0_ZERO && (rd_addr_b == '0)) rd_data_b = '0;
  end

endmodule

// File: tb/tb_regfile16x16_wb.sv
// Self-checking bench for regfile16x16_wb: directed scenarios plus randomized
// traffic compared against an array model updated at write acceptance.
module tb_regfile16x16_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic        clr_req;
  logic        busy;
  logic        clr_done;

  int unsigned pass_cnt = 0;
  int unsigned chk_cnt  = 0;
  logic [15:0] model [16];

  regfile16x16_wb #(.DATA_W(16), .ADDR_W(4), .R0_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = 4'd3; rd_addr_b = 4'd9; clr_req = 1'b0;
    model_clear();
    #12;
    chk_cnt++;
    if ({busy, clr_done, wr_ready, rd_data_a, rd_data_b} !== {3'b001, 32'h0})
      $display("FAIL reset_during busy/done/ready/a/b=%b%b%b %h %h want 001 0 0",
               busy, clr_done, wr_ready, rd_data_a, rd_data_b);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    cyc();
    chk_cnt++;
    if ({busy, clr_done, wr_ready, rd_data_a, rd_data_b} !== {3'b001, 32'h0})
      $display("FAIL reset_after busy/done/ready/a/b=%b%b%b %h %h want 001 0 0",
               busy, clr_done, wr_ready, rd_data_a, rd_data_b);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF; rd_addr_a = 4'd5;
    cyc();
    model[5] = 16'hBEEF;
    wr_valid = 1'b0;
    chk_cnt++;
    if (rd_data_a !== 16'hBEEF) $display("FAIL bypass_read got %h want BEEF", rd_data_a);
    else pass_cnt++;
    cyc();
    chk_cnt++;
    if (rd_data_a !== 16'hBEEF) $display("FAIL array_read got %h want BEEF", rd_data_a);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      wr_valid = 1'b1; wr_addr = 4'(i); wr_data = 16'(i * 16'h1111);
      chk_cnt++;
      if (wr_ready !== 1'b1) $display("FAIL b2b_ready cycle %0d got %b want 1", i, wr_ready);
      else pass_cnt++;
      cyc();
      model[i] = 16'(i * 16'h1111);
    end
    wr_valid = 1'b0;
    cyc();
    for (int i = 1; i <= 3; i++) begin
      rd_addr_a = 4'(i); rd_addr_b = 4'(i);
      #1;
      chk_cnt++;
      if (rd_data_a !== model[i] || rd_data_b !== model[i])
        $display("FAIL b2b_read addr %0d got a=%h b=%h want %h", i, rd_data_a, rd_data_b, model[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_r0();
    wr_valid = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    chk_cnt++;
    if (wr_ready !== 1'b1) $display("FAIL r0_ready got %b want 1", wr_ready);
    else pass_cnt++;
    cyc();
    wr_valid = 1'b0;
    chk_cnt++;
    if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0)
      $display("FAIL r0_bypass got a=%h b=%h want 0000", rd_data_a, rd_data_b);
    else pass_cnt++;
    cyc();
    chk_cnt++;
    if (rd_data_a !== 16'h0) $display("FAIL r0_array got %h want 0000", rd_data_a);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int unsigned errs;
    errs = 0;
    for (int n = 0; n < 200; n++) begin
      wr_valid  = 1'($urandom_range(0, 1));
      wr_addr   = 4'($urandom_range(0, 15));
      wr_data   = 16'($urandom);
      rd_addr_a = ($urandom_range(0, 1) == 1) ? wr_addr : 4'($urandom_range(0, 15));
      rd_addr_b = 4'($urandom_range(0, 15));
      cyc();
      if (wr_valid && wr_addr != 4'd0) model[wr_addr] = wr_data;
      chk_cnt++;
      if (rd_data_a !== model[rd_addr_a] || rd_data_b !== model[rd_addr_b]) begin
        errs++;
        if (errs <= 5)
          $display("FAIL random_read n=%0d a[%0d]=%h want %h b[%0d]=%h want %h", n,
                   rd_addr_a, rd_data_a, model[rd_addr_a], rd_addr_b, rd_data_b, model[rd_addr_b]);
      end else pass_cnt++;
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_clear();
    int unsigned busy_cycles, done_seen, ready_bad;
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1; wr_addr = 4'(i); wr_data = 16'($urandom) | 16'h0001;
      cyc();
      if (i != 0) model[i] = wr_data;
    end
    wr_valid = 1'b0;
    clr_req  = 1'b1;
    cyc();
    clr_req = 1'b0;
    wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 16'hDEAD;
    busy_cycles = 0; done_seen = 0; ready_bad = 0;
    for (int c = 0; c < 16; c++) begin
      if (busy === 1'b1) busy_cycles++;
      if (wr_ready !== 1'b0) ready_bad++;
      if (clr_done === 1'b1) done_seen++;
      cyc();
    end
    chk_cnt++;
    if (busy_cycles != 16) $display("FAIL clr_busy_len got %0d want 16", busy_cycles);
    else pass_cnt++;
    chk_cnt++;
    if (ready_bad != 0) $display("FAIL clr_ready_low got %0d cycles ready want 0", ready_bad);
    else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b0 || clr_done !== 1'b1 || done_seen != 0)
      $display("FAIL clr_done_pulse got busy=%b done=%b early=%0d want 0 1 0", busy, clr_done, done_seen);
    else pass_cnt++;
    wr_valid = 1'b0;
    model_clear();
    rd_addr_a = 4'd7; rd_addr_b = 4'd7;
    #1;
    chk_cnt++;
    if (rd_data_a !== 16'h0) $display("FAIL clr_no_accept got %h want 0000", rd_data_a);
    else pass_cnt++;
    cyc();
    chk_cnt++;
    if (clr_done !== 1'b0) $display("FAIL clr_done_width got %b want 0", clr_done);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i);
      #1;
      chk_cnt++;
      if (rd_data_a !== model[i] || rd_data_b !== model[15 - i])
        $display("FAIL clr_zero addr %0d got a=%h b=%h want 0000", i, rd_data_a, rd_data_b);
      else pass_cnt++;
    end
  endtask

  task automatic test_clr_with_write();
    wr_valid = 1'b1; wr_addr = 4'd6; wr_data = 16'h5A5A;
    cyc();
    model[6] = 16'h5A5A;
    wr_addr = 4'd0; wr_data = 16'h1234; clr_req = 1'b1;
    cyc();
    wr_valid = 1'b0; clr_req = 1'b0;
    for (int c = 0; c < 16; c++) cyc();
    model_clear();
    rd_addr_a = 4'd0; rd_addr_b = 4'd6;
    #1;
    chk_cnt++;
    if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0 || busy !== 1'b0)
      $display("FAIL clr_with_write got a=%h b=%h busy=%b want 0000 0000 0", rd_data_a, rd_data_b, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_sweep();
    for (int i = 1; i < 16; i++) begin
      wr_valid = 1'b1; wr_addr = 4'(i); wr_data = 16'hC000 | 16'(i);
      cyc();
    end
    wr_valid = 1'b0; clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    for (int c = 0; c < 7; c++) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (busy !== 1'b0 || wr_ready !== 1'b1)
      $display("FAIL rst_mid_busy got busy=%b ready=%b want 0 1", busy, wr_ready);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    cyc();
    model_clear();
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i); rd_addr_b = 4'(i);
      #1;
      chk_cnt++;
      if (rd_data_a !== model[i] || rd_data_b !== model[i] || wr_ready !== 1'b1 || busy !== 1'b0)
        $display("FAIL rst_mid_state addr %0d got a=%h b=%h ready=%b busy=%b want 0000 0000 1 0",
                 i, rd_data_a, rd_data_b, wr_ready, busy);
      else pass_cnt++;
    end
    wr_valid = 1'b1; wr_addr = 4'd9; wr_data = 16'hA5A5;
    cyc();
    wr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    rd_addr_a = 4'd9;
    cyc();
    cyc();
    chk_cnt++;
    if (rd_data_a !== 16'h0) $display("FAIL rst_pending got %h want 0000", rd_data_a);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_back_to_back();
    test_r0();
    test_random();
    test_clear();
    test_clr_with_write();
    test_random();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
